// File: rtl/nbit_down_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nbit_down_timer_pkg
// Description : Shared definitions for the auto-reloading down-timer:
//               FSM state encodings and default widths.
// Contents    : c_state_idle / c_state_run  - 1-bit FSM state encodings
//               c_count_bits_default         - default count/reload width
//               c_pending_bits_default       - default pending-counter width
// Revision    : 1.0 - initial release
// ============================================================================
package nbit_down_timer_pkg;

    localparam logic [0:0] c_state_idle = 1'b0;
    localparam logic [0:0] c_state_run  = 1'b1;

    localparam int c_count_bits_default   = 8;
    localparam int c_pending_bits_default = 2;

endpackage : nbit_down_timer_pkg
`default_nettype wire

// File: rtl/nbit_down_timer_adder.sv
`default_nettype none
// ============================================================================
// Module      : nbit_down_timer_adder
// Description : N-bit full adder (sum = a + b + cin, modulo 2^BITWIDTH).
//               Shared with the up-counter; the down-timer uses it as a
//               decrementer by tying one operand to all-ones.
// Ports       : a, b  [BITWIDTH-1:0] in  - operands
//               cin   1             in  - carry in
//               sum   [BITWIDTH-1:0] out - truncated sum
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_down_timer_adder #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic                cin,
    output logic [BITWIDTH-1:0] sum
);

    assign sum = a + b + {{(BITWIDTH-1){1'b0}}, cin};

endmodule : nbit_down_timer_adder
`default_nettype wire

// File: rtl/nbit_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : nbit_down_timer
// Description : Loadable, auto-reloading N-bit down-counter. Each terminal
//               count (count 1 -> reload) produces a one-cycle tc pulse that
//               is queued in a saturating pending counter and presented to
//               the consumer as a level request with an ack handshake.
// Ports       : clk       in   system clock (rising edge)
//               rst       in   asynchronous active-high reset
//               ld        in   load strobe, captures load_val
//               en        in   count enable
//               load_val  in   [COUNT_BITS-1:0] period / reload value
//               count     out  [COUNT_BITS-1:0] current count
//               tc        out  one-cycle terminal-count pulse
//               req       out  high while pending != 0
//               ack       in   retires one pending event when req is high
//               pending   out  [PENDING_BITS-1:0] queued events
//               overflow  out  sticky: an event was dropped at saturation
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_down_timer
    import nbit_down_timer_pkg::*;
#(
    parameter int COUNT_BITS   = c_count_bits_default,
    parameter int PENDING_BITS = c_pending_bits_default,
    parameter int PATH_DELAY   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld,
    input  logic                    en,
    input  logic [COUNT_BITS-1:0]   load_val,
    output logic [COUNT_BITS-1:0]   count,
    output logic                    tc,
    output logic                    req,
    input  logic                    ack,
    output logic [PENDING_BITS-1:0] pending,
    output logic                    overflow
);

    localparam logic [PENDING_BITS-1:0] c_pending_max = {PENDING_BITS{1'b1}};
    localparam logic [COUNT_BITS-1:0]   c_count_one   = {{(COUNT_BITS-1){1'b0}}, 1'b1};

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [COUNT_BITS-1:0]   r_count;
    logic [COUNT_BITS-1:0]   r_reload;
    logic                    r_tc;
    logic [PENDING_BITS-1:0] r_pending;
    logic                    r_req;
    logic                    r_overflow;

    logic [COUNT_BITS-1:0]   w_count_dec;
    logic [COUNT_BITS-1:0]   w_count_nxt;
    logic [COUNT_BITS-1:0]   w_reload_nxt;
    logic                    w_tc_nxt;
    logic                    w_ovf_clr;
    logic                    w_ovf_set;
    logic                    w_load_nz;
    logic                    w_load_zero;
    logic                    w_inc;
    logic                    w_dec;
    logic [PENDING_BITS-1:0] w_pending_nxt;

    assign w_load_nz   = ld && (load_val != '0);
    assign w_load_zero = ld && (load_val == '0);

    // ------------------------------------------------------------------
    // Decrementer: count + all-ones == count - 1 (mod 2^COUNT_BITS).
    // PATH_DELAY only shapes timing in simulation wrappers; the core
    // carries no delays. A negative value is meaningless and falls back
    // to an inline decrement so the datapath is still well defined.
    // ------------------------------------------------------------------
    generate
        if (PATH_DELAY >= 0) begin : g_dec_adder
            nbit_down_timer_adder #(
                .BITWIDTH (COUNT_BITS)
            ) u_dec (
                .a   ({COUNT_BITS{1'b1}}),
                .b   (r_count),
                .cin (1'b0),
                .sum (w_count_dec)
            );
        end else begin : g_dec_inline
            assign w_count_dec = r_count - c_count_one;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_state_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_state_idle: if (w_load_nz)   w_state_nxt = c_state_run;
            c_state_run:  if (w_load_zero) w_state_nxt = c_state_idle;
            default:                       w_state_nxt = c_state_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: datapath control (next count / reload / tc / overflow clear)
    // ld has priority over en; a zero load parks the timer in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        w_ovf_clr    = 1'b0;
        case (r_state)
            c_state_idle: begin
                if (ld) begin
                    w_reload_nxt = load_val;
                end
                if (w_load_nz) begin
                    w_count_nxt = load_val;
                    w_ovf_clr   = 1'b1;
                end
            end
            c_state_run: begin
                if (w_load_nz) begin
                    w_count_nxt  = load_val;
                    w_reload_nxt = load_val;
                    w_ovf_clr    = 1'b1;
                end else if (w_load_zero) begin
                    w_count_nxt  = '0;
                    w_reload_nxt = '0;
                end else if (en) begin
                    if (r_count == c_count_one) begin
                        w_count_nxt = r_reload;
                        w_tc_nxt    = 1'b1;
                    end else begin
                        w_count_nxt = w_count_dec;
                    end
                end
            end
            default: begin
                w_count_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending-event counter. The tc event is consumed the edge after it
    // is registered, so req follows the first tc by one cycle. A
    // simultaneous event and ack cancel out.
    // ------------------------------------------------------------------
    assign w_inc = r_tc;
    assign w_dec = ack && r_req;

    always_comb begin
        w_pending_nxt = r_pending;
        w_ovf_set     = 1'b0;
        if (w_inc && !w_dec) begin
            if (r_pending == c_pending_max) begin
                w_ovf_set = 1'b1;
            end else begin
                w_pending_nxt = r_pending + 1'b1;
            end
        end else if (w_dec && !w_inc) begin
            w_pending_nxt = r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_reload   <= '0;
            r_tc       <= 1'b0;
            r_pending  <= '0;
            r_req      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_tc      <= w_tc_nxt;
            r_pending <= w_pending_nxt;
            r_req     <= (w_pending_nxt != '0);
            // A fresh load wins over a drop at the same edge.
            if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign count    = r_count;
    assign tc       = r_tc;
    assign req      = r_req;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule : nbit_down_timer
`default_nettype wire
